// File: rtl/fp_addsub_seq_if.sv
// Handshake bundle for the multi-cycle FP adder: operand side, result side and flags.
// Word layout is {sign, exponent, fraction}, matching the adder's parameters.
interface fp_addsub_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         flag_overflow;
   logic         flag_underflow;
   logic         flag_invalid;
   logic         flag_inexact;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, result,
      input  flag_overflow, flag_underflow, flag_invalid, flag_inexact
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, result,
      output flag_overflow, flag_underflow, flag_invalid, flag_inexact
   );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even, flushing denormals.
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic           clk,
   input logic           rst,
   fp_addsub_seq_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 4;                 // hidden + fraction + guard/round/sticky
   localparam int LZW = $clog2(SW + 1);
   localparam int EW  = EXP_W + LZW + 2;           // signed working exponent
   localparam logic [EXP_W-1:0] EXP_MAX   = '1;
   localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W + 3);
   localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state_reg, state_next;

   logic [W-1:0]         a_reg, b_reg;
   logic                 sub_reg;
   logic                 sign_x_reg, eff_sub_reg;
   logic signed [EW-1:0] exp_x_reg;
   logic [SW-1:0]        sig_x_reg, sig_y_reg;
   logic                 spec_reg, spec_inv_reg;
   logic [W-1:0]         spec_val_reg;
   logic [SW:0]          sum_reg;
   logic signed [EW-1:0] exp_n_reg;
   logic [SW-1:0]        sig_n_reg;
   logic                 zero_n_reg, uf_n_reg;
   logic [W-1:0]         result_reg;
   logic                 ov_reg, uf_reg, inv_reg, inx_reg;

   logic in_ready_c, out_valid_c, capture;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (capture) state_next = ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready_c  = (state_reg == IDLE) && !rst;
      out_valid_c = (state_reg == DONE);
   end

   assign capture = bus.in_valid && in_ready_c;

   // ---------------- ALIGN: classify, swap, shift ----------------
   logic                 sa, sb, sx_c, sy_c, a_gt;
   logic [EXP_W-1:0]     ea, eb, ex, ey, d;
   logic [MAN_W-1:0]     fa, fb, fx, fy;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [SW-1:0]        y_full, y_shift, sig_x_c, sig_y_c;
   logic                 y_lost;
   logic                 spec_c, spec_inv_c;
   logic [W-1:0]         spec_val_c;

   always_comb begin
      sa     = a_reg[W-1];
      sb     = b_reg[W-1] ^ sub_reg;
      ea     = a_reg[W-2 -: EXP_W];
      eb     = b_reg[W-2 -: EXP_W];
      fa     = a_reg[MAN_W-1:0];
      fb     = b_reg[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_MAX) && (fa == '0);
      b_inf  = (eb == EXP_MAX) && (fb == '0);
      a_nan  = (ea == EXP_MAX) && (fa != '0);
      b_nan  = (eb == EXP_MAX) && (fb != '0);

      a_gt = a_reg[W-2:0] >= b_reg[W-2:0];
      ex   = a_gt ? ea : eb;
      ey   = a_gt ? eb : ea;
      fx   = a_gt ? fa : fb;
      fy   = a_gt ? fb : fa;
      sx_c = a_gt ? sa : sb;
      sy_c = a_gt ? sb : sa;
      d    = ex - ey;

      sig_x_c = {1'b1, fx, 3'b000};
      y_full  = {1'b1, fy, 3'b000};
      y_shift = y_full >> d;
      y_lost  = |(y_full & ~({SW{1'b1}} << d));
      // Far-apart operands collapse to a lone sticky bit
      if (d >= SHIFT_LIM) sig_y_c = {{(SW-1){1'b0}}, 1'b1};
      else                sig_y_c = {y_shift[SW-1:1], y_shift[0] | y_lost};

      spec_c     = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
      spec_inv_c = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         spec_val_c = QNAN;
         spec_inv_c = 1'b1;
      end else if (a_inf)            spec_val_c = {sa, a_reg[W-2:0]};
      else if (b_inf)                spec_val_c = {sb, b_reg[W-2:0]};
      else if (a_zero && b_zero)     spec_val_c = {sa & sb, {(W-1){1'b0}}};
      else if (a_zero)               spec_val_c = {sb, b_reg[W-2:0]};
      else                           spec_val_c = a_reg;
   end

   // ---------------- NORM: carry shift or leading-zero shift ----------------
   logic [LZW-1:0]       lz_c;
   logic [SW-1:0]        sig_n_c;
   logic signed [EW-1:0] exp_n_c;
   logic                 zero_n_c, uf_n_c;

   always_comb begin
      lz_c = '0;
      for (int i = 0; i < SW; i++) begin
         if (sum_reg[i]) lz_c = LZW'(SW - 1 - i);
      end
      if (sum_reg[SW]) begin
         sig_n_c = {sum_reg[SW:2], sum_reg[1] | sum_reg[0]};
         exp_n_c = exp_x_reg + EW'(1);
      end else begin
         sig_n_c = sum_reg[SW-1:0] << lz_c;
         exp_n_c = exp_x_reg - $signed({{(EW-LZW){1'b0}}, lz_c});
      end
      zero_n_c = (sum_reg == '0);
      uf_n_c   = !zero_n_c && (exp_n_c <= 0);
   end

   // ---------------- ROUND: nearest-even and final packing ----------------
   logic                 g_c, r_c, s_c, rup_c;
   logic [MAN_W+1:0]     mant_c;
   logic [MAN_W-1:0]     frac_c;
   logic signed [EW-1:0] exp_f_c;
   logic [W-1:0]         res_c;
   logic                 ov_c, uf_c, inv_c, inx_c;

   always_comb begin
      g_c     = sig_n_reg[2];
      r_c     = sig_n_reg[1];
      s_c     = sig_n_reg[0];
      rup_c   = g_c & (r_c | s_c | sig_n_reg[3]);
      mant_c  = {1'b0, sig_n_reg[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup_c};
      frac_c  = mant_c[MAN_W+1] ? mant_c[MAN_W:1] : mant_c[MAN_W-1:0];
      exp_f_c = exp_n_reg + $signed({{(EW-1){1'b0}}, mant_c[MAN_W+1]});

      res_c = '0;
      ov_c  = 1'b0;
      uf_c  = 1'b0;
      inv_c = 1'b0;
      inx_c = 1'b0;
      if (spec_reg) begin
         res_c = spec_val_reg;
         inv_c = spec_inv_reg;
      end else if (zero_n_reg) begin
         res_c = '0;
      end else if (uf_n_reg) begin
         res_c = {sign_x_reg, {(W-1){1'b0}}};
         uf_c  = 1'b1;
         inx_c = 1'b1;
      end else if (exp_f_c >= $signed({{(EW-EXP_W){1'b0}}, EXP_MAX})) begin
         res_c = {sign_x_reg, EXP_MAX, {MAN_W{1'b0}}};
         ov_c  = 1'b1;
         inx_c = 1'b1;
      end else begin
         res_c = {sign_x_reg, exp_f_c[EXP_W-1:0], frac_c};
         inx_c = g_c | r_c | s_c;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         sub_reg      <= 1'b0;
         sign_x_reg   <= 1'b0;
         eff_sub_reg  <= 1'b0;
         exp_x_reg    <= '0;
         sig_x_reg    <= '0;
         sig_y_reg    <= '0;
         spec_reg     <= 1'b0;
         spec_inv_reg <= 1'b0;
         spec_val_reg <= '0;
         sum_reg      <= '0;
         exp_n_reg    <= '0;
         sig_n_reg    <= '0;
         zero_n_reg   <= 1'b0;
         uf_n_reg     <= 1'b0;
         result_reg   <= '0;
         ov_reg       <= 1'b0;
         uf_reg       <= 1'b0;
         inv_reg      <= 1'b0;
         inx_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (capture) begin
               a_reg   <= bus.op_a;
               b_reg   <= bus.op_b;
               sub_reg <= bus.sub;
               ov_reg  <= 1'b0;
               uf_reg  <= 1'b0;
               inv_reg <= 1'b0;
               inx_reg <= 1'b0;
            end
            ALIGN: begin
               sign_x_reg   <= sx_c;
               eff_sub_reg  <= sx_c ^ sy_c;
               exp_x_reg    <= $signed({{(EW-EXP_W){1'b0}}, ex});
               sig_x_reg    <= sig_x_c;
               sig_y_reg    <= sig_y_c;
               spec_reg     <= spec_c;
               spec_inv_reg <= spec_inv_c;
               spec_val_reg <= spec_val_c;
            end
            ADD: begin
               if (eff_sub_reg) sum_reg <= {1'b0, sig_x_reg} - {1'b0, sig_y_reg};
               else             sum_reg <= {1'b0, sig_x_reg} + {1'b0, sig_y_reg};
            end
            NORM: begin
               exp_n_reg  <= exp_n_c;
               sig_n_reg  <= sig_n_c;
               zero_n_reg <= zero_n_c;
               uf_n_reg   <= uf_n_c;
            end
            ROUND: begin
               result_reg <= res_c;
               ov_reg     <= ov_c;
               uf_reg     <= uf_c;
               inv_reg    <= inv_c;
               inx_reg    <= inx_c;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready       = in_ready_c;
   assign bus.out_valid      = out_valid_c;
   assign bus.result         = result_reg;
   assign bus.flag_overflow  = ov_reg;
   assign bus.flag_underflow = uf_reg;
   assign bus.flag_invalid   = inv_reg;
   assign bus.flag_inexact   = inx_reg;
endmodule
